dec8_to_hex27: RTL

//  Sequential 8-digit packed-BCD to 27-bit binary converter; inverse of the binary-to-decimal converter.

---
 rtl/dec_conv_defs.sv | 25 ++
 rtl/dec8_to_hex27_bcd_mac10.sv | 28 ++
 rtl/dec8_to_hex27.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dec_conv_defs.sv
// Shared definitions for the BCD <-> binary converters.
// Digit count, binary width, BCD digit width and the control-state encodings.
// Pure declarations: no logic, no latency, no flow control.
package dec_conv_defs;

  localparam int ND   = 8;          // number of BCD digits
  localparam int NB   = 27;         // binary result width (99_999_999 < 2^27)
  localparam int DW   = 4;          // width of one BCD digit
  localparam int DECW = ND * DW;    // packed BCD input width

  // Control-state encodings; 2'd3 is never entered on purpose.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } state_t;

  // Pointer value loaded at start: index of the most significant digit.
  localparam logic [3:0] PTR_MSD = 4'(ND - 1);

endpackage

// File: rtl/dec8_to_hex27_bcd_mac10.sv
// Multiply-accumulate step for decimal-to-binary conversion: acc*10 + digit.
// Purely combinational, zero latency.
// No flow control; also flags a digit outside 0..9.
import dec_conv_defs::*;

module bcd_mac10 #(
  parameter int NB = dec_conv_defs::NB
) (
  input  logic [NB-1:0] acc_in,
  input  logic [3:0]    dig,
  output logic [NB-1:0] acc_out,
  output logic          bad
);

  logic [NB-1:0] times8;
  logic [NB-1:0] times2;
  logic [NB-1:0] dig_ext;

  // acc*10 built from two shifts; result wraps modulo 2^NB.
  always_comb begin
    times8  = {acc_in[NB-4:0], 3'b000};
    times2  = {acc_in[NB-2:0], 1'b0};
    dig_ext = {{(NB-4){1'b0}}, dig};
    acc_out = times8 + times2 + dig_ext;
    bad     = (dig > 4'd9);
  end

endmodule

// File: rtl/dec8_to_hex27.sv
// Sequential 8-digit packed-BCD to 27-bit binary converter, one digit per clock, MSD first.
// Latency: st sampled at edge k, done pulses with Dbin valid after edge k+9.
// No queuing: st while busy is dropped; next start accepted at edge k+10 earliest.
import dec_conv_defs::*;

module dec8_to_hex27 (
  input  logic            clk,
  input  logic            rst,
  input  logic            st,
  input  logic [DECW-1:0] Ddec,
  output logic [NB-1:0]   Dbin,
  output logic            done,
  output logic            busy,
  output logic [3:0]      ptr_dig,
  output logic            err
);

  state_t          state, state_nx;
  logic [DECW-1:0] sr, sr_nx;
  logic [NB-1:0]   acc, acc_nx;
  logic            errf, errf_nx;
  logic [NB-1:0]   dbin_nx;
  logic            err_nx;
  logic            done_nx;
  logic            busy_nx;
  logic [3:0]      ptr_nx;

  logic [NB-1:0]   mac_acc;
  logic            mac_bad;

  bcd_mac10 #(.NB(NB)) u_mac (
    .acc_in  (acc),
    .dig     (sr[DECW-1 -: DW]),
    .acc_out (mac_acc),
    .bad     (mac_bad)
  );

  // State and datapath registers; async reset returns everything to zero/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      acc     <= '0;
      errf    <= 1'b0;
      Dbin    <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ptr_dig <= 4'd0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      acc     <= acc_nx;
      errf    <= errf_nx;
      Dbin    <= dbin_nx;
      err     <= err_nx;
      done    <= done_nx;
      busy    <= busy_nx;
      ptr_dig <= ptr_nx;
    end
  end

  // Next-state and next-register values; busy stays high through the done cycle.
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    acc_nx   = acc;
    errf_nx  = errf;
    dbin_nx  = Dbin;
    err_nx   = err;
    done_nx  = 1'b0;
    busy_nx  = busy;
    ptr_nx   = ptr_dig;

    case (state)
      ST_IDLE: begin
        busy_nx = 1'b0;
        ptr_nx  = 4'd0;
        if (st) begin
          state_nx = ST_CONV;
          sr_nx    = Ddec;
          acc_nx   = '0;
          errf_nx  = 1'b0;
          ptr_nx   = PTR_MSD;
          busy_nx  = 1'b1;
        end
      end

      ST_CONV: begin
        acc_nx  = mac_acc;
        errf_nx = errf | mac_bad;
        sr_nx   = {sr[DECW-DW-1:0], {DW{1'b0}}};
        busy_nx = 1'b1;
        if (ptr_dig == 4'd0) begin
          ptr_nx   = 4'd0;
          state_nx = ST_DONE;
        end else begin
          ptr_nx = ptr_dig - 4'd1;
        end
      end

      ST_DONE: begin
        dbin_nx  = acc;
        err_nx   = errf;
        done_nx  = 1'b1;
        busy_nx  = 1'b1;
        ptr_nx   = 4'd0;
        state_nx = ST_IDLE;
      end

      default: begin
        // Unused encoding: fall back to IDLE with every register at its reset value.
        state_nx = ST_IDLE;
        sr_nx    = '0;
        acc_nx   = '0;
        errf_nx  = 1'b0;
        dbin_nx  = '0;
        err_nx   = 1'b0;
        busy_nx  = 1'b0;
        ptr_nx   = 4'd0;
      end
    endcase
  end

endmodule
